// File: rtl/piso_serializer_if.sv
// Handshake bundle for the PISO serializer: parallel load side plus serial output side.
interface piso_serializer_if #(
    parameter int N = 8
);
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] load_data;
    logic         ser_ready;
    logic         ser_valid;
    logic         ser_data;
    logic         ser_first;
    logic         ser_last;
    logic         busy;

    modport slave (
        input  load_valid, load_data, ser_ready,
        output load_ready, ser_valid, ser_data, ser_first, ser_last, busy
    );

    modport master (
        output load_valid, load_data, ser_ready,
        input  load_ready, ser_valid, ser_data, ser_first, ser_last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter with valid/ready on both sides and gapless back-to-back words.
//   state | meaning
//   IDLE  | no word held, load side open
//   SHIFT | word being emitted, one bit per accepted serial beat
module piso_serializer #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    piso_serializer_if.slave  bus
);
    localparam int            CW     = $clog2(N);
    localparam logic [CW-1:0] LAST   = CW'(N - 1);
    localparam logic [CW-1:0] PENULT = CW'(N - 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         r_state;
    logic [N-1:0]   r_shreg;
    logic [CW-1:0]  r_count;
    logic           r_ser_valid;
    logic           r_ser_data;
    logic           r_ser_first;
    logic           r_ser_last;
    logic           r_busy;

    logic           w_last;
    logic           w_load_ready;
    logic           w_load;
    logic           w_beat;
    logic [N-1:0]   w_shifted;
    logic           w_next_bit;
    logic           w_load_bit;

    assign w_last       = (r_count == LAST);
    // A new word may only enter on the beat that retires the current last bit.
    assign w_load_ready = !rst && ((r_state == IDLE) ||
                                   ((r_state == SHIFT) && w_last && bus.ser_ready));
    assign w_load       = bus.load_valid && w_load_ready;
    assign w_beat       = r_ser_valid && bus.ser_ready;

    generate
        if (LSB_FIRST) begin : g_lsb
            assign w_shifted  = r_shreg >> 1;
            assign w_next_bit = r_shreg[1];
            assign w_load_bit = bus.load_data[0];
        end else begin : g_msb
            assign w_shifted  = r_shreg << 1;
            assign w_next_bit = r_shreg[N-2];
            assign w_load_bit = bus.load_data[N-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_count     <= '0;
            r_ser_valid <= 1'b0;
            r_ser_data  <= 1'b0;
            r_ser_first <= 1'b0;
            r_ser_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_load) begin
            r_state     <= SHIFT;
            r_shreg     <= bus.load_data;
            r_count     <= '0;
            r_ser_valid <= 1'b1;
            r_ser_data  <= w_load_bit;
            r_ser_first <= 1'b1;
            r_ser_last  <= 1'b0;
            r_busy      <= 1'b1;
        end else if ((r_state == SHIFT) && w_beat) begin
            if (!w_last) begin
                r_shreg     <= w_shifted;
                r_count     <= r_count + 1'b1;
                r_ser_data  <= w_next_bit;
                r_ser_first <= 1'b0;
                r_ser_last  <= (r_count == PENULT);
            end else begin
                r_state     <= IDLE;
                r_count     <= '0;
                r_ser_valid <= 1'b0;
                r_ser_first <= 1'b0;
                r_ser_last  <= 1'b0;
                r_busy      <= 1'b0;
            end
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.ser_valid  = r_ser_valid;
    assign bus.ser_data   = r_ser_data;
    assign bus.ser_first  = r_ser_first;
    assign bus.ser_last   = r_ser_last;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_piso_serializer.sv
// Drives LSB-first and MSB-first serializers with shared stimulus; each has its own bit scoreboard.
module tb_piso_serializer;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [N-1:0] load_data;
    logic         ser_ready;
    bit           chk_en = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic chk(input int id, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", id, tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam bit LSB = (g == 0);

        piso_serializer_if #(.N(N)) bus ();
        assign bus.load_valid = load_valid;
        assign bus.load_data  = load_data;
        assign bus.ser_ready  = ser_ready;

        piso_serializer #(.N(N), .LSB_FIRST(LSB)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        // each entry: {bit, first, last}, pushed on load, popped on beat
        logic [2:0] q[$];
        bit         post_rst = 1'b0;

        always @(negedge clk) begin
            logic       exp_lr;
            logic [2:0] e;
            int         idx;
            if (chk_en) begin
                exp_lr = !rst && ((q.size() == 0) || ((q.size() == 1) && ser_ready));
                chk(g, "load_ready", bus.load_ready, exp_lr);
                chk(g, "ser_valid", bus.ser_valid, q.size() != 0);
                chk(g, "busy", bus.busy, q.size() != 0);
                if (post_rst) begin
                    chk(g, "rst ser_data", bus.ser_data, 0);
                    chk(g, "rst ser_first", bus.ser_first, 0);
                    chk(g, "rst ser_last", bus.ser_last, 0);
                    post_rst = 1'b0;
                end
                if (q.size() != 0) begin
                    e = q[0];
                    chk(g, "ser_data", bus.ser_data, e[2]);
                    chk(g, "ser_first", bus.ser_first, e[1]);
                    chk(g, "ser_last", bus.ser_last, e[0]);
                end
                if (rst) begin
                    q.delete();
                    post_rst = 1'b1;
                end else begin
                    if ((q.size() != 0) && ser_ready) void'(q.pop_front());
                    if (load_valid && exp_lr) begin
                        for (int i = 0; i < N; i++) begin
                            idx = LSB ? i : (N - 1 - i);
                            q.push_back({load_data[idx], (i == 0), (i == N - 1)});
                        end
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [N-1:0] w);
        load_valid = 1'b1;
        load_data  = w;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = N'($urandom);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hA5;
        ser_ready  = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        load_valid = 1'b0;
        idle(1);

        // single words, both bit orders checked by their own scoreboards
        load_word(8'hA5);
        idle(10);
        load_word(8'h01);
        idle(10);

        // stall three cycles while bit 2 is presented; a waiting load must stay blocked
        load_word(8'h96);
        idle(1);
        ser_ready  = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h5A;
        idle(3);
        ser_ready  = 1'b1;
        load_valid = 1'b0;
        idle(10);

        // stall on the last bit with a load pending; it enters only with the last beat
        load_word(8'h0F);
        idle(7);
        ser_ready  = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h77;
        idle(2);
        ser_ready  = 1'b1;
        idle(1);
        load_valid = 1'b0;
        idle(10);

        // back-to-back words with load_valid held high
        load_valid = 1'b1;
        load_data  = 8'hFF;
        @(posedge clk);
        #1;
        load_data  = 8'h00;
        repeat (8) @(posedge clk);
        #1;
        load_valid = 1'b0;
        idle(10);

        // reset while bit 4 is presented, then a clean word
        load_word(8'h3C);
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        load_word(8'hC3);
        idle(10);

        // random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data  = N'($urandom);
            ser_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        ser_ready  = 1'b1;
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
